// File: rtl/booth_pkg.sv
// Shared types and default widths for the Booth multiplier sequencer.
package booth_pkg;

    localparam int unsigned WIDTH_IN      = 16;
    localparam int unsigned WIDTH_PRODUCT = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOAD_PP,
        WAIT
    } state_e;

    typedef struct packed {
        logic [WIDTH_IN-1:0] a;
        logic [WIDTH_IN-1:0] b;
    } operand_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO; power-of-two depth, pointers wrap naturally.
module booth_op_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type payload_t = booth_pkg::operand_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  payload_t                 push_data,
    input  logic                     pop,
    output payload_t                 pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    payload_t         mem_q [DEPTH];
    payload_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Feeds buffered operand pairs to the Booth multiplier, waits for its product
// (with a timeout watchdog) and presents the result on a valid/ready stream.
module booth_mul_sequencer #(
    parameter int unsigned WIDTH_IN      = booth_pkg::WIDTH_IN,
    parameter int unsigned WIDTH_PRODUCT = booth_pkg::WIDTH_PRODUCT,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TIMEOUT       = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [WIDTH_IN-1:0]      op_a,
    input  logic [WIDTH_IN-1:0]      op_b,
    output logic [WIDTH_IN-1:0]      mul_a,
    output logic [WIDTH_IN-1:0]      mul_b,
    output logic                     mul_ld,
    output logic                     mul_ld_pp,
    input  logic                     mul_ld_p,
    input  logic [WIDTH_PRODUCT-1:0] mul_product,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH_PRODUCT-1:0] res_product,
    output logic                     res_err,
    output logic                     busy
);

    import booth_pkg::*;

    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH_IN-1:0] a;
        logic [WIDTH_IN-1:0] b;
    } op_pair_t;

    state_e                   state_q, state_d;
    logic [WIDTH_IN-1:0]      mul_a_q, mul_a_d;
    logic [WIDTH_IN-1:0]      mul_b_q, mul_b_d;
    logic                     mul_ld_q, mul_ld_d;
    logic                     mul_ld_pp_q, mul_ld_pp_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     res_valid_q, res_valid_d;
    logic [WIDTH_PRODUCT-1:0] res_product_q, res_product_d;
    logic                     res_err_q, res_err_d;
    logic                     rdy_en_q, rdy_en_d;

    op_pair_t                 fifo_in, fifo_head;
    logic                     fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [FCNT_W-1:0]        fifo_count;
    logic                     res_load;

    // op_ready stays low while in reset and for the partial cycle after release
    assign op_ready    = rdy_en_q && !fifo_full;
    assign fifo_push   = op_valid && op_ready;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_ld      = mul_ld_q;
    assign mul_ld_pp   = mul_ld_pp_q;
    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign res_err     = res_err_q;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);

    booth_op_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .payload_t (op_pair_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        fifo_in.a     = op_a;
        fifo_in.b     = op_b;
        state_d       = state_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        mul_ld_d      = 1'b0;
        mul_ld_pp_d   = 1'b0;
        cnt_d         = cnt_q;
        res_product_d = res_product_q;
        res_err_d     = res_err_q;
        res_load      = 1'b0;
        rdy_en_d      = 1'b1;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && (!res_valid_q || res_ready)) begin
                    fifo_pop = 1'b1;
                    mul_a_d  = fifo_head.a;
                    mul_b_d  = fifo_head.b;
                    mul_ld_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                mul_ld_pp_d = 1'b1;
                state_d     = LOAD_PP;
            end
            LOAD_PP: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A product arriving on the last allowed cycle beats the watchdog
                if (mul_ld_p) begin
                    res_load      = 1'b1;
                    res_product_d = mul_product;
                    res_err_d     = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_load      = 1'b1;
                    res_product_d = '0;
                    res_err_d     = 1'b1;
                    state_d       = IDLE;
                end
            end
        endcase

        if (res_load) begin
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_ld_q      <= 1'b0;
            mul_ld_pp_q   <= 1'b0;
            cnt_q         <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_err_q     <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            mul_ld_q      <= mul_ld_d;
            mul_ld_pp_q   <= mul_ld_pp_d;
            cnt_q         <= cnt_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            res_err_q     <= res_err_d;
            rdy_en_q      <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Self-checking bench: vector table, behavioural multiplier model, result scoreboard.
module tb_booth_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b, mul_a, mul_b;
    logic        mul_ld, mul_ld_pp, mul_ld_p;
    logic [31:0] mul_product, res_product;
    logic        res_valid, res_ready, res_err, busy;

    always #5 clk = ~clk;

    booth_mul_sequencer #(
        .WIDTH_IN      (16),
        .WIDTH_PRODUCT (32),
        .FIFO_DEPTH    (4),
        .TIMEOUT       (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ld      (mul_ld),
        .mul_ld_pp   (mul_ld_pp),
        .mul_ld_p    (mul_ld_p),
        .mul_product (mul_product),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .res_err     (res_err),
        .busy        (busy)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          delay;     // cycles from ld_pp to ld_p; -1 = never
        bit          fixed;
        logic [31:0] fprod;
        logic [31:0] exp_prod;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] prod;
        bit          err;
        int          lat;
    } exp_t;

    typedef struct {
        int          delay;
        bit          fixed;
        logic [31:0] fprod;
    } rsp_t;

    vec_t        vecs [15];
    exp_t        sb_q [$];
    logic [31:0] op_q [$];
    rsp_t        rsp_q [$];

    int checks = 0;
    int failures = 0;
    int results_seen = 0;
    int ld_pulses = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural multiplier: answers each ld_pp after the requested delay
    initial begin
        rsp_t        r;
        bit          aborted;
        int          sa, sbv;
        mul_ld_p    = 1'b0;
        mul_product = '0;
        forever begin
            @(posedge clk); #1;
            if (reset && mul_ld_pp) begin
                if (rsp_q.size() != 0) r = rsp_q.pop_front();
                else r = '{delay: 18, fixed: 1'b0, fprod: 32'h0};
                sa  = int'($signed(mul_a));
                sbv = int'($signed(mul_b));
                aborted = 1'b0;
                if (r.delay >= 0) begin
                    for (int i = 0; i < r.delay; i++) begin
                        @(posedge clk);
                        if (!reset) aborted = 1'b1;
                    end
                    #1;
                    if (!aborted && reset) begin
                        mul_ld_p    = 1'b1;
                        mul_product = r.fixed ? r.fprod : 32'(sa * sbv);
                        @(posedge clk); #1;
                        mul_ld_p    = 1'b0;
                    end
                end
            end
        end
    end

    // Output monitor and scoreboard
    bit          prev_ld = 1'b0, prev_rv = 1'b0, track = 1'b0;
    logic [15:0] la, lb;
    int          pp_cyc = 0;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] eop;
        if (!reset) begin
            prev_ld = 1'b0;
            prev_rv = 1'b0;
            track   = 1'b0;
        end else begin
            if (mul_ld) begin
                ld_pulses++;
                check("ld_has_operand", 64'(op_q.size() != 0), 1);
                if (op_q.size() != 0) begin
                    eop = op_q.pop_front();
                    check("ld_operands", {mul_a, mul_b}, eop);
                end
                la = mul_a;
                lb = mul_b;
                track = 1'b1;
            end else if (track) begin
                check("operand_stable", {mul_a, mul_b}, {la, lb});
            end
            if (prev_ld) check("ld_then_pp", {mul_ld, mul_ld_pp}, 2'b01);
            if (mul_ld_pp) begin
                check("pp_after_ld", 64'(prev_ld), 1);
                pp_cyc = cyc;
            end
            if (res_valid && !prev_rv) begin
                track = 1'b0;
                if (sb_q.size() != 0) check("result_latency", 64'(cyc - pp_cyc), 64'(sb_q[0].lat));
            end
            if (res_valid && res_ready) begin
                check("result_expected", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("res_product", res_product, e.prod);
                    check("res_err", 64'(res_err), 64'(e.err));
                end
                results_seen++;
            end
            prev_ld = mul_ld;
            prev_rv = res_valid;
        end
    end

    task automatic push_op(input vec_t v);
        bit   accepted = 1'b0;
        exp_t e;
        rsp_t r;
        op_valid = 1'b1;
        op_a = v.a;
        op_b = v.b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (op_ready) begin
                accepted = 1'b1;
                e.prod = v.exp_prod;
                e.err  = v.exp_err;
                e.lat  = (v.delay >= 0 && v.delay <= 40) ? v.delay + 1 : 41;
                sb_q.push_back(e);
                op_q.push_back({v.a, v.b});
                r.delay = v.delay;
                r.fixed = v.fixed;
                r.fprod = v.fprod;
                rsp_q.push_back(r);
                break;
            end
            @(posedge clk); #1;
        end
        if (accepted) begin
            @(posedge clk); #1;
        end else begin
            check("push_accept", 0, 1);
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int budget);
        for (int i = 0; i < budget && results_seen < target; i++) begin
            @(posedge clk); #1;
        end
        check("results_arrived", 64'(results_seen >= target), 1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, n;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b1;
        //         a        b        dly fix fprod         exp_prod      err
        vecs[0]  = '{16'd3,    16'hFFFE, 18, 0, 32'h0,        32'hFFFFFFFA, 0};
        vecs[1]  = '{16'd2,    16'd3,    18, 0, 32'h0,        32'd6,        0};
        vecs[2]  = '{16'd4,    16'd5,    3,  0, 32'h0,        32'd20,       0};
        vecs[3]  = '{16'd7,    16'd7,    1,  0, 32'h0,        32'd49,       0};
        vecs[4]  = '{16'h7FFF, 16'd2,    10, 0, 32'h0,        32'h0000FFFE, 0};
        vecs[5]  = '{16'd1,    16'd1,    18, 0, 32'h0,        32'd1,        0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 4,  0, 32'h0,        32'd1,        0};
        vecs[7]  = '{16'd100,  16'd200,  6,  0, 32'h0,        32'h00004E20, 0};
        vecs[8]  = '{16'd5,    16'd5,    -1, 0, 32'h0,        32'h0,        1};
        vecs[9]  = '{16'h8000, 16'h8000, 5,  0, 32'h0,        32'h40000000, 0};
        vecs[10] = '{16'd9,    16'd9,    40, 1, 32'h12345678, 32'h12345678, 0};
        vecs[11] = '{16'd9,    16'd9,    41, 1, 32'h12345678, 32'h0,        1};
        vecs[12] = '{16'hFFFF, 16'd5,    39, 0, 32'h0,        32'hFFFFFFFB, 0};
        vecs[13] = '{16'd1,    16'd2,    -1, 0, 32'h0,        32'h0,        1};
        vecs[14] = '{16'd6,    16'd7,    18, 0, 32'h0,        32'd42,       0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", 64'(op_ready), 0);
        check("rst_mul_a", 64'(mul_a), 0);
        check("rst_mul_b", 64'(mul_b), 0);
        check("rst_mul_ld", 64'({mul_ld, mul_ld_pp}), 0);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_res_product", 64'(res_product), 0);
        check("rst_res_err", 64'(res_err), 0);
        check("rst_busy", 64'(busy), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("release_op_ready", 64'(op_ready), 1);

        // Single op with load latency
        push_op(vecs[0]);
        check("ld_not_yet", 64'(mul_ld), 0);
        check("busy_after_push", 64'(busy), 1);
        @(posedge clk); #1;
        check("ld_latency", 64'(mul_ld), 1);
        wait_results(1, 100);

        // Fill: one in flight, four buffered
        for (int i = 1; i <= 5; i++) push_op(vecs[i]);
        check("fill_op_ready_low", 64'(op_ready), 0);
        wait_results(6, 400);
        check("fill_op_ready_back", 64'(op_ready), 1);

        // Backpressure on the result stream
        res_ready = 1'b0;
        n = ld_pulses;
        push_op(vecs[6]);
        push_op(vecs[7]);
        for (int i = 0; i < 100 && !res_valid; i++) wait_cycles(1);
        wait_cycles(10);
        check("bp_hold_valid", 64'(res_valid), 1);
        check("bp_no_second_ld", 64'(ld_pulses - n), 1);
        check("bp_product_held", 64'(res_product), 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain_and_load", 64'({mul_ld, res_valid}), 64'(2'b10));
        wait_results(8, 100);

        // Timeout, recovery, ld_p/timeout race and neighbours
        for (int i = 8; i <= 12; i++) push_op(vecs[i]);
        wait_results(13, 600);

        // Asynchronous reset mid-WAIT with three ops queued
        for (int i = 0; i < 4; i++) push_op(vecs[13]);
        wait_cycles(6);
        #3;
        reset = 1'b0;
        #1;
        check("arst_mul_ab", 64'({mul_a, mul_b}), 0);
        check("arst_mul_ld", 64'({mul_ld, mul_ld_pp}), 0);
        check("arst_res", 64'({res_valid, res_err}), 0);
        check("arst_res_product", 64'(res_product), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_op_ready", 64'(op_ready), 0);
        sb_q.delete();
        op_q.delete();
        rsp_q.delete();
        base = results_seen;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", 64'(op_ready), 1);
        check("post_reset_idle", 64'({busy, res_valid}), 0);
        push_op(vecs[14]);
        wait_results(base + 1, 100);
        wait_cycles(60);
        check("no_stale_results", 64'(results_seen - base), 1);
        check("final_res_valid", 64'(res_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
